// File: rtl/led_pkg.sv
// Shared mode and state encodings for the LED pattern shifter.
package led_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_ROT_L = 2'b00;
  localparam mode_t MODE_ROT_R = 2'b01;
  localparam mode_t MODE_FLASH = 2'b10;
  localparam mode_t MODE_PP    = 2'b11;

  typedef enum logic [2:0] {
    ST_ROT_L = 3'd0,
    ST_ROT_R = 3'd1,
    ST_FLASH = 3'd2,
    ST_PP_UP = 3'd3,
    ST_PP_DN = 3'd4
  } state_t;

  function automatic state_t mode_state(input mode_t m);
    case (m)
      MODE_ROT_R: return ST_ROT_R;
      MODE_FLASH: return ST_FLASH;
      MODE_PP:    return ST_PP_UP;
      default:    return ST_ROT_L;
    endcase
  endfunction

endpackage

// File: rtl/led_tick_qualifier.sv
// Gates the rate tick with the run-enable switch; purely combinational.
module led_tick_qualifier (
  input  logic i_valid,
  input  logic i_enable,
  output logic o_tick
);

  assign o_tick = i_valid & i_enable;

endmodule

// File: rtl/led_pattern_shifter.sv
// LED pattern register advanced on each qualified rate tick, mode selected by switches.
// Define LED_PINGPONG_EN to give mode 11 a ping-pong pattern; otherwise it aliases rotate-left.
module led_pattern_shifter
  import led_pkg::*;
#(
  parameter int NB_LEDS = 4,
  parameter int NB_MODE = 2
) (
  input  logic               clock,
  input  logic               i_reset,
  input  logic               i_valid,
  input  logic               i_enable,
  input  logic [NB_MODE-1:0] i_mode,
  output logic [NB_LEDS-1:0] o_led,
  output logic               o_wrap
);

  localparam logic [NB_LEDS-1:0] SEED = {{(NB_LEDS-1){1'b0}}, 1'b1};
  localparam logic [NB_LEDS-1:0] ONES = {NB_LEDS{1'b1}};

  function automatic logic [NB_LEDS-1:0] start_pat(input logic [NB_MODE-1:0] m);
    return (m == MODE_FLASH) ? ONES : SEED;
  endfunction

  logic               tick;
  logic [NB_MODE-1:0] eff_mode, mode_q, mode_d;
  state_t             state_q, state_d;
  logic [NB_LEDS-1:0] led_d, shl, shr;
  logic               wrap_d, legal;

  led_tick_qualifier u_tick (
    .i_valid  (i_valid),
    .i_enable (i_enable),
    .o_tick   (tick)
  );

`ifdef LED_PINGPONG_EN
  assign eff_mode = i_mode;
`else
  // Mode 11 folds onto rotate-left so even the reload/wrap timing matches mode 00.
  assign eff_mode = (i_mode == MODE_PP) ? MODE_ROT_L : i_mode;
`endif

  assign shl = {o_led[NB_LEDS-2:0], o_led[NB_LEDS-1]};
  assign shr = {o_led[0], o_led[NB_LEDS-1:1]};

  always_comb begin
    state_d = state_q;
    led_d   = o_led;
    mode_d  = mode_q;
    wrap_d  = 1'b0;
    legal   = 1'b1;
    if (tick) begin
      if (eff_mode != mode_q) begin
        mode_d  = eff_mode;
        state_d = mode_state(eff_mode);
        led_d   = start_pat(eff_mode);
      end else begin
        case (state_q)
          ST_ROT_L: led_d = shl;
          ST_ROT_R: led_d = shr;
          ST_FLASH: led_d = ~o_led;
`ifdef LED_PINGPONG_EN
          ST_PP_UP: begin
            led_d = shl;
            if (shl[NB_LEDS-1]) state_d = ST_PP_DN;
          end
          ST_PP_DN: begin
            led_d = shr;
            if (shr == SEED) state_d = ST_PP_UP;
          end
`endif
          default: begin
            legal   = 1'b0;
            state_d = ST_ROT_L;
            led_d   = SEED;
            mode_d  = MODE_ROT_L;
          end
        endcase
        wrap_d = legal && (led_d == start_pat(mode_q));
      end
    end
  end

  always_ff @(posedge clock) begin
    if (i_reset) begin
      state_q <= ST_ROT_L;
      o_led   <= SEED;
      o_wrap  <= 1'b0;
      mode_q  <= MODE_ROT_L;
    end else begin
      state_q <= state_d;
      o_led   <= led_d;
      o_wrap  <= wrap_d;
      mode_q  <= mode_d;
    end
  end

endmodule
